// File: rtl/dma_priority_arbiter_pkg.sv
// Shared types and constants for the DMA request/priority stage.
package dma_priority_arbiter_pkg;

  localparam int unsigned NumCh = 4;

  // Bit positions of the one-hot arbiter state, used for reverse-case decoding.
  localparam int unsigned IdxIdle  = 0;
  localparam int unsigned IdxReq   = 1;
  localparam int unsigned IdxGrant = 2;
  localparam int unsigned IdxDone  = 3;

  typedef enum logic [3:0] {
    PIdle  = 4'b0001,
    PReq   = 4'b0010,
    PGrant = 4'b0100,
    PDone  = 4'b1000
  } arb_state_e;

  typedef logic [1:0] ch_idx_t;

  function automatic logic [NumCh-1:0] ch_onehot(input ch_idx_t idx);
    return NumCh'(1) << idx;
  endfunction

endpackage

// File: rtl/dma_priority_encoder.sv
// Rotating-start priority search: first pending channel at or above ptr, wrapping mod NumCh.
module dma_priority_encoder
  import dma_priority_arbiter_pkg::*;
(
  input  logic [NumCh-1:0] pending,
  input  ch_idx_t          ptr,
  output logic             found,
  output ch_idx_t          idx
);

  ch_idx_t cand;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int i = 0; i < NumCh; i++) begin
      cand = ptr + ch_idx_t'(i);
      if (!found && pending[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/dma_priority_arbiter.sv
// 8237A-style DMA request/priority stage: DREQ sampling, arbitration, HRQ/HLDA handshake and DACK.
module dma_priority_arbiter
  import dma_priority_arbiter_pkg::*;
(
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic [NumCh-1:0] DREQ,
  input  logic             HLDA,
  input  logic             EOP_N,
  input  logic [7:0]       commandReg,
  input  logic [NumCh-1:0] maskReg,
  input  logic [NumCh-1:0] requestReg,
  input  logic             idleCycle,
  input  logic             validDACK,
  input  logic             serviceDone,
  output logic             HRQ,
  output logic [NumCh-1:0] VALID_DREQ,
  output logic [NumCh-1:0] DACK,
  output ch_idx_t          activeCh,
  output logic [NumCh-1:0] clrReqBit
);

  arb_state_e       state_q, state_d;
  ch_idx_t          ptr_q, ptr_d, winner_q, winner_d, search_ptr, found_idx;
  logic [NumCh-1:0] dreq_sync_q, pending, valid_q, valid_d, dack_raw;
  logic             hrq_q, hrq_d, eop_seen_q, eop_seen_d, found;
  logic             unused_cmd;

  assign unused_cmd = ^{commandReg[5], commandReg[3], commandReg[1:0]};

  // Software requests bypass the mask.
  assign pending    = (dreq_sync_q & ~maskReg) | requestReg;
  assign search_ptr = commandReg[4] ? ptr_q : '0;

  dma_priority_encoder u_encoder (
    .pending (pending),
    .ptr     (search_ptr),
    .found   (found),
    .idx     (found_idx)
  );

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    winner_d   = winner_q;
    hrq_d      = hrq_q;
    valid_d    = valid_q;
    eop_seen_d = eop_seen_q;
    dack_raw   = '0;
    clrReqBit  = '0;
    unique case (1'b1)
      state_q[IdxIdle]: begin
        eop_seen_d = 1'b0;
        if (idleCycle && !commandReg[2] && found) begin
          winner_d = found_idx;
          hrq_d    = 1'b1;
          valid_d  = ch_onehot(found_idx);
          state_d  = PReq;
        end
      end
      state_q[IdxReq]: begin
        if (!pending[winner_q]) begin
          hrq_d   = 1'b0;
          valid_d = '0;
          state_d = PIdle;
        end else if (HLDA) begin
          state_d = PGrant;
        end
      end
      state_q[IdxGrant]: begin
        dack_raw   = ch_onehot(winner_q) & {NumCh{validDACK}};
        eop_seen_d = eop_seen_q | ~EOP_N;
        if (!HLDA) begin
          hrq_d   = 1'b0;
          valid_d = '0;
          state_d = PIdle;
        end else if (serviceDone) begin
          state_d = PDone;
        end
      end
      state_q[IdxDone]: begin
        // Serviced channel drops to lowest priority; fixed mode pins the pointer to 0.
        ptr_d = commandReg[4] ? winner_q + 2'd1 : '0;
        if (eop_seen_q || !EOP_N) clrReqBit = ch_onehot(winner_q);
        hrq_d   = 1'b0;
        valid_d = '0;
        state_d = PIdle;
      end
      default: begin
        hrq_d   = 1'b0;
        valid_d = '0;
        state_d = PIdle;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state_q     <= PIdle;
      ptr_q       <= '0;
      winner_q    <= '0;
      dreq_sync_q <= '0;
      hrq_q       <= 1'b0;
      valid_q     <= '0;
      eop_seen_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      winner_q    <= winner_d;
      dreq_sync_q <= DREQ ^ {NumCh{commandReg[6]}};
      hrq_q       <= hrq_d;
      valid_q     <= valid_d;
      eop_seen_q  <= eop_seen_d;
    end
  end

  assign HRQ        = hrq_q;
  assign VALID_DREQ = valid_q;
  assign activeCh   = winner_q;
  assign DACK       = dack_raw ^ {NumCh{~commandReg[7]}};

endmodule

// File: tb/tb_dma_priority_arbiter.sv
// Directed bench for dma_priority_arbiter with hand-computed expectations.
module tb_dma_priority_arbiter;

  logic       CLK = 1'b0;
  logic       RESET_N, HLDA, EOP_N, idleCycle, validDACK, serviceDone;
  logic [3:0] DREQ, maskReg, requestReg;
  logic [7:0] commandReg;
  logic       HRQ;
  logic [3:0] VALID_DREQ, DACK, clrReqBit;
  logic [1:0] activeCh;

  int vectors = 0;
  int miscompares = 0;

  dma_priority_arbiter dut (
    .CLK         (CLK),
    .RESET_N     (RESET_N),
    .DREQ        (DREQ),
    .HLDA        (HLDA),
    .EOP_N       (EOP_N),
    .commandReg  (commandReg),
    .maskReg     (maskReg),
    .requestReg  (requestReg),
    .idleCycle   (idleCycle),
    .validDACK   (validDACK),
    .serviceDone (serviceDone),
    .HRQ         (HRQ),
    .VALID_DREQ  (VALID_DREQ),
    .DACK        (DACK),
    .activeCh    (activeCh),
    .clrReqBit   (clrReqBit)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One full transaction from idle; DREQ/requests must already be set by the caller.
  task automatic serve(input logic [1:0] ch);
    logic [3:0] oh;
    logic [3:0] exp_dack;
    oh = 4'b0001 << ch;
    exp_dack = commandReg[7] ? oh : ~oh;
    step();
    step();
    idleCycle = 1'b1;
    for (int i = 0; i < 8 && HRQ !== 1'b1; i++) step();
    chk("hrq_rise", {7'b0, HRQ}, 8'd1);
    idleCycle = 1'b0;
    chk("valid_dreq", {4'b0, VALID_DREQ}, {4'b0, oh});
    chk("active_ch", {6'b0, activeCh}, {6'b0, ch});
    HLDA = 1'b1;
    step();
    validDACK = 1'b1;
    #1;
    chk("dack_grant", {4'b0, DACK}, {4'b0, exp_dack});
    validDACK = 1'b0;
    serviceDone = 1'b1;
    step();
    serviceDone = 1'b0;
    HLDA = 1'b0;
    chk("hrq_in_done", {7'b0, HRQ}, 8'd1);
    chk("clr_none", {4'b0, clrReqBit}, 8'd0);
    step();
    chk("hrq_turnaround", {7'b0, HRQ}, 8'd0);
    chk("valid_cleared", {4'b0, VALID_DREQ}, 8'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    RESET_N = 1'b0; DREQ = 4'hF; HLDA = 1'b0; EOP_N = 1'b1; commandReg = 8'h00;
    maskReg = 4'h0; requestReg = 4'h0; idleCycle = 1'b0; validDACK = 1'b0; serviceDone = 1'b0;

    // Reset
    step();
    step();
    chk("rst_hrq", {7'b0, HRQ}, 8'd0);
    chk("rst_valid", {4'b0, VALID_DREQ}, 8'd0);
    chk("rst_dack", {4'b0, DACK}, 8'h0F);
    chk("rst_clr", {4'b0, clrReqBit}, 8'd0);
    chk("rst_active", {6'b0, activeCh}, 8'd0);
    RESET_N = 1'b1;
    DREQ = 4'h0;
    step();

    // Fixed priority, two-cycle request latency
    DREQ = 4'b1010;
    idleCycle = 1'b1;
    step();
    chk("fix_hrq_lat1", {7'b0, HRQ}, 8'd0);
    step();
    chk("fix_hrq_lat2", {7'b0, HRQ}, 8'd1);
    chk("fix_valid", {4'b0, VALID_DREQ}, 8'b0010);
    idleCycle = 1'b0;
    HLDA = 1'b1;
    step();
    validDACK = 1'b1;
    #1;
    chk("fix_dack", {4'b0, DACK}, 8'b1101);
    validDACK = 1'b0;
    serviceDone = 1'b1;
    step();
    serviceDone = 1'b0;
    HLDA = 1'b0;
    DREQ = 4'h0;
    step();
    chk("fix_hrq_off", {7'b0, HRQ}, 8'd0);

    // Rotating priority with all channels requesting
    commandReg = 8'h10;
    DREQ = 4'hF;
    serve(2'd0);
    serve(2'd1);
    serve(2'd2);
    serve(2'd3);
    serve(2'd0);

    // Controller disable blocks arbitration
    commandReg = 8'h14;
    idleCycle = 1'b1;
    step();
    step();
    step();
    chk("disable_no_hrq", {7'b0, HRQ}, 8'd0);
    idleCycle = 1'b0;

    // Mask vs software request, EOP clears the request bit
    commandReg = 8'h00;
    DREQ = 4'h1;
    maskReg = 4'h1;
    idleCycle = 1'b1;
    step();
    step();
    step();
    chk("masked_no_hrq", {7'b0, HRQ}, 8'd0);
    requestReg = 4'h1;
    step();
    chk("swreq_hrq", {7'b0, HRQ}, 8'd1);
    chk("swreq_valid", {4'b0, VALID_DREQ}, 8'b0001);
    idleCycle = 1'b0;
    HLDA = 1'b1;
    step();
    EOP_N = 1'b0;
    serviceDone = 1'b1;
    step();
    EOP_N = 1'b1;
    serviceDone = 1'b0;
    HLDA = 1'b0;
    requestReg = 4'h0;
    #1;
    chk("eop_clr_pulse", {4'b0, clrReqBit}, 8'b0001);
    step();
    chk("eop_clr_gone", {4'b0, clrReqBit}, 8'd0);
    chk("eop_hrq_off", {7'b0, HRQ}, 8'd0);
    maskReg = 4'h0;
    DREQ = 4'h0;

    // Abort before HLDA leaves the pointer alone
    commandReg = 8'h10;
    DREQ = 4'b0101;
    serve(2'd0);
    DREQ = 4'b0100;
    step();
    step();
    idleCycle = 1'b1;
    step();
    chk("abort_hrq", {7'b0, HRQ}, 8'd1);
    chk("abort_ch", {6'b0, activeCh}, 8'd2);
    idleCycle = 1'b0;
    DREQ = 4'h0;
    step();
    step();
    chk("abort_hrq_off", {7'b0, HRQ}, 8'd0);
    chk("abort_valid_off", {4'b0, VALID_DREQ}, 8'd0);
    DREQ = 4'b0011;
    serve(2'd1);

    // HLDA falling in grant returns to idle without rotation
    DREQ = 4'b1000;
    step();
    step();
    idleCycle = 1'b1;
    step();
    chk("hlda_drop_ch", {6'b0, activeCh}, 8'd3);
    idleCycle = 1'b0;
    HLDA = 1'b1;
    step();
    validDACK = 1'b1;
    #1;
    chk("hlda_drop_dack", {4'b0, DACK}, 8'b0111);
    HLDA = 1'b0;
    step();
    chk("hlda_drop_hrq", {7'b0, HRQ}, 8'd0);
    chk("hlda_drop_valid", {4'b0, VALID_DREQ}, 8'd0);
    chk("hlda_drop_dack_off", {4'b0, DACK}, 8'h0F);
    validDACK = 1'b0;
    DREQ = 4'b1001;
    serve(2'd3);

    // Active-low DREQ and active-high DACK
    commandReg = 8'hC0;
    DREQ = 4'b1110;
    #1;
    chk("pol_dack_idle", {4'b0, DACK}, 8'd0);
    serve(2'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
